cpu_bus_stim_mem: RTL and testbench

- Synthesizable CPU-side memory and stimulus model for CPU bench and FPGA bring-up.
- Provides a parametrised RAM window with asynchronous read and synchronous write, a programmable 6-byte vector file at FFFA-FFFF, and a backdoor image-load port.
- Contains two programmable interrupt generators, IRQ and NMI. Each is an FSM with start, length and repeat period.
- A CPU-writable mailbox signals end-of-test.

---
 rtl/cpu_bus_stim_mem_pkg.sv | 34 +++
 rtl/cpu_bus_stim_mem_if.sv | 20 ++
 rtl/cpu_bus_stim_mem_stim_irq_chan.sv | 99 +++++++++
 rtl/cpu_bus_stim_mem.sv | 129 ++++++++++++
 tb/tb_cpu_bus_stim_mem.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_stim_mem_pkg.sv
// Shared types and constants for the CPU bus stimulus/memory model.
package cpu_stim_pkg;

   // Interrupt channel states
   typedef enum logic [2:0] {
      CH_DIS,
      CH_WAIT,
      CH_ACT,
      CH_GAP,
      CH_DONE
   } chan_state_e;

   // cfg_addr register map (bit 2 selects the NMI channel)
   localparam logic [2:0] CFG_IRQ_START = 3'd0;
   localparam logic [2:0] CFG_IRQ_LEN   = 3'd1;
   localparam logic [2:0] CFG_IRQ_PER   = 3'd2;
   localparam logic [2:0] CFG_IRQ_EN    = 3'd3;
   localparam logic [2:0] CFG_NMI_START = 3'd4;
   localparam logic [2:0] CFG_NMI_LEN   = 3'd5;
   localparam logic [2:0] CFG_NMI_PER   = 3'd6;
   localparam logic [2:0] CFG_NMI_EN    = 3'd7;

   // Per-channel register index (cfg_addr[1:0])
   localparam logic [1:0] CH_REG_START = 2'd0;
   localparam logic [1:0] CH_REG_LEN   = 2'd1;
   localparam logic [1:0] CH_REG_PER   = 2'd2;
   localparam logic [1:0] CH_REG_EN    = 2'd3;

   // Vector file addresses (little-endian 16-bit vectors)
   localparam logic [15:0] VEC_NMI_ADDR = 16'hFFFA;
   localparam logic [15:0] VEC_RST_ADDR = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ_ADDR = 16'hFFFE;

endpackage

// File: rtl/cpu_bus_stim_mem_if.sv
// CPU-side bus: address/data/direction from the CPU, read data and
// active-low interrupt requests back to it.
interface cpu_bus_stim_mem_if;
   logic [15:0] Addr_bus;
   logic [7:0]  Data_bus_out;
   logic        R_nW;
   logic [7:0]  Data_bus_in;
   logic        irq;
   logic        nmi;

   modport master (
      output Addr_bus, Data_bus_out, R_nW,
      input  Data_bus_in, irq, nmi
   );

   modport slave (
      input  Addr_bus, Data_bus_out, R_nW,
      output Data_bus_in, irq, nmi
   );
endinterface

// File: rtl/cpu_bus_stim_mem_stim_irq_chan.sv
// One programmable interrupt channel: delay, pulse length and repeat
// period, producing a registered active-low request.
module stim_irq_chan
   import cpu_stim_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_ph1,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_idx,
   input  logic [CNT_W-1:0] cfg_wdata,
   output logic             out_n
);

   chan_state_e      state;
   logic [CNT_W-1:0] t;
   logic [CNT_W-1:0] t_nxt;
   logic [CNT_W-1:0] start_r;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] per_r;
   logic             en_r;
   logic [CNT_W-1:0] len_eff;
   logic [CNT_W-1:0] gap_len;

   // Effective pulse length (0 behaves as 1), gap length and next count
   always_comb begin
      t_nxt   = t + 1'b1;
      len_eff = (len_r == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : len_r;
      gap_len = per_r - len_eff;
   end

   // Channel FSM; a config write is applied after the FSM step so it wins
   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         state   <= CH_DIS;
         t       <= '0;
         start_r <= '0;
         len_r   <= '0;
         per_r   <= '0;
         en_r    <= 1'b0;
         out_n   <= 1'b1;
      end else begin
         unique case (state)
            CH_WAIT: begin
               if (start_r == '0 || t_nxt >= start_r) begin
                  state <= CH_ACT;
                  t     <= '0;
                  out_n <= 1'b0;
               end else begin
                  t <= t_nxt;
               end
            end
            CH_ACT: begin
               if (t_nxt >= len_eff) begin
                  t <= '0;
                  // Period no longer than the pulse: stay low continuously
                  if (per_r != '0 && per_r <= len_eff) begin
                     out_n <= 1'b0;
                  end else begin
                     state <= CH_GAP;
                     out_n <= 1'b1;
                  end
               end else begin
                  t <= t_nxt;
               end
            end
            CH_GAP: begin
               if (per_r == '0) begin
                  state <= CH_DONE;
                  out_n <= 1'b1;
               end else if (per_r <= len_eff || t_nxt >= gap_len) begin
                  state <= CH_ACT;
                  t     <= '0;
                  out_n <= 1'b0;
               end else begin
                  t <= t_nxt;
               end
            end
            default: out_n <= 1'b1;
         endcase

         if (cfg_we) begin
            unique case (cfg_idx)
               CH_REG_START: start_r <= cfg_wdata;
               CH_REG_LEN:   len_r   <= cfg_wdata;
               CH_REG_PER:   per_r   <= cfg_wdata;
               default: begin
                  en_r  <= cfg_wdata[0];
                  state <= cfg_wdata[0] ? CH_WAIT : CH_DIS;
                  t     <= '0;
                  out_n <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/cpu_bus_stim_mem.sv
// CPU memory and stimulus model: RAM window, vector file, backdoor load,
// end-of-test mailbox, free-running cycle counter and IRQ/NMI generators.
module cpu_bus_stim_mem
   import cpu_stim_pkg::*;
#(
   parameter int unsigned RAM_AW    = 12,
   parameter logic [7:0]  FILL      = 8'h00,
   parameter logic [15:0] MBOX_ADDR = 16'h6000,
   parameter logic [15:0] RST_VEC   = 16'h0000,
   parameter logic [15:0] NMI_VEC   = 16'h2000,
   parameter logic [15:0] IRQ_VEC   = 16'h2000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk_ph1,
   input  logic                 rst,
   cpu_bus_stim_mem_if.slave    bus,
   input  logic                 ld_we,
   input  logic [15:0]          ld_addr,
   input  logic [7:0]           ld_data,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_addr,
   input  logic [CNT_W-1:0]     cfg_wdata,
   output logic [CNT_W-1:0]     cyc,
   output logic                 done,
   output logic [7:0]           done_code
);

   localparam int unsigned RAM_SIZE = 1 << RAM_AW;

   logic [7:0] mem [RAM_SIZE];
   logic [7:0] vec_r [6];

   logic       cpu_ram, cpu_vec, ld_ram, ld_vec, cpu_wr;
   logic [2:0] cpu_vidx, ld_vidx;
   logic       irq_sel, nmi_sel, irq_n, nmi_n;

   // Address decode for the CPU and backdoor ports
   always_comb begin
      cpu_vec  = bus.Addr_bus >= VEC_NMI_ADDR;
      cpu_ram  = 32'(bus.Addr_bus) < RAM_SIZE;
      ld_vec   = ld_addr >= VEC_NMI_ADDR;
      ld_ram   = 32'(ld_addr) < RAM_SIZE;
      cpu_vidx = 3'(bus.Addr_bus - VEC_NMI_ADDR);
      ld_vidx  = 3'(ld_addr - VEC_NMI_ADDR);
      cpu_wr   = !bus.R_nW;
   end

   // Zero-latency read mux; vector file shadows any overlapping RAM
   always_comb begin
      bus.Data_bus_in = FILL;
      if (cpu_vec) begin
         bus.Data_bus_in = vec_r[cpu_vidx];
      end else if (cpu_ram) begin
         bus.Data_bus_in = mem[bus.Addr_bus[RAM_AW-1:0]];
      end
   end

   // RAM (never reset); backdoor write issued last so it wins a same-byte collision
   always_ff @(posedge clk_ph1) begin
      if (cpu_wr && cpu_ram && !cpu_vec) begin
         mem[bus.Addr_bus[RAM_AW-1:0]] <= bus.Data_bus_out;
      end
      if (ld_we && ld_ram && !ld_vec) begin
         mem[ld_addr[RAM_AW-1:0]] <= ld_data;
      end
   end

   // Vector file, reloaded from parameters on reset, written only by backdoor
   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         vec_r[0] <= NMI_VEC[7:0];
         vec_r[1] <= NMI_VEC[15:8];
         vec_r[2] <= RST_VEC[7:0];
         vec_r[3] <= RST_VEC[15:8];
         vec_r[4] <= IRQ_VEC[7:0];
         vec_r[5] <= IRQ_VEC[15:8];
      end else if (ld_we && ld_vec) begin
         vec_r[ld_vidx] <= ld_data;
      end
   end

   // Sticky end-of-test mailbox
   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         done      <= 1'b0;
         done_code <= '0;
      end else if (cpu_wr && bus.Addr_bus == MBOX_ADDR) begin
         done      <= 1'b1;
         done_code <= bus.Data_bus_out;
      end
   end

   // Cycles since reset release, wrapping
   always_ff @(posedge clk_ph1) begin
      if (!rst) begin
         cyc <= '0;
      end else begin
         cyc <= cyc + 1'b1;
      end
   end

   // Route config writes to the channel addressed by cfg_addr[2]
   always_comb begin
      nmi_sel = cfg_addr >= CFG_NMI_START;
      irq_sel = !nmi_sel;
   end

   stim_irq_chan #(.CNT_W(CNT_W)) u_irq (
      .clk_ph1   (clk_ph1),
      .rst       (rst),
      .cfg_we    (cfg_we && irq_sel),
      .cfg_idx   (cfg_addr[1:0]),
      .cfg_wdata (cfg_wdata),
      .out_n     (irq_n)
   );

   stim_irq_chan #(.CNT_W(CNT_W)) u_nmi (
      .clk_ph1   (clk_ph1),
      .rst       (rst),
      .cfg_we    (cfg_we && nmi_sel),
      .cfg_idx   (cfg_addr[1:0]),
      .cfg_wdata (cfg_wdata),
      .out_n     (nmi_n)
   );

   assign bus.irq = irq_n;
   assign bus.nmi = nmi_n;

endmodule

// File: tb/tb_cpu_bus_stim_mem.sv
// Self-checking bench for cpu_bus_stim_mem: directed scenarios plus
// randomized bus traffic and channel configurations against a reference model.
module tb_cpu_bus_stim_mem;

   logic        clk_ph1 = 1'b0;
   logic        rst = 1'b0;
   logic        ld_we = 1'b0;
   logic [15:0] ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [15:0] cfg_wdata = '0;
   logic [15:0] cyc;
   logic        done;
   logic [7:0]  done_code;

   cpu_bus_stim_mem_if bus();

   cpu_bus_stim_mem #(
      .RAM_AW(12), .FILL(8'h00), .MBOX_ADDR(16'h6000), .RST_VEC(16'h0000),
      .NMI_VEC(16'h2000), .IRQ_VEC(16'h2000), .CNT_W(16)
   ) dut (
      .clk_ph1   (clk_ph1),
      .rst       (rst),
      .bus       (bus),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cyc       (cyc),
      .done      (done),
      .done_code (done_code)
   );

   always #5 clk_ph1 = ~clk_ph1;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state
   logic [7:0] ram_m [64];
   bit         wr_m [64];
   logic [7:0] vec_m [6];
   logic       done_m;
   logic [7:0] code_m;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected active-low level k edges after EN=1 was written
   function automatic logic chan_model(int k, int s, int l, int p);
      int se, le, ph;
      se = (s == 0) ? 1 : s;
      le = (l == 0) ? 1 : l;
      if (k < se) return 1'b1;
      ph = k - se;
      if (p == 0) return !(ph < le);
      if (p <= le) return 1'b0;
      return !((ph % p) < le);
   endfunction

   function automatic logic [7:0] exp_read(input logic [15:0] a);
      if (a >= 16'hFFFA) return vec_m[a - 16'hFFFA];
      if (a < 16'h1000) return ram_m[a[5:0]];
      return 8'h00;
   endfunction

   task automatic model_reset();
      vec_m[0] = 8'h00; vec_m[1] = 8'h20;
      vec_m[2] = 8'h00; vec_m[3] = 8'h00;
      vec_m[4] = 8'h00; vec_m[5] = 8'h20;
      done_m = 1'b0;
      code_m = 8'h00;
   endtask

   task automatic model_cpu(input logic [15:0] a, input logic [7:0] d);
      if (a < 16'h1000) begin
         ram_m[a[5:0]] = d;
         wr_m[a[5:0]] = 1'b1;
      end else if (a == 16'h6000) begin
         done_m = 1'b1;
         code_m = d;
      end
   endtask

   task automatic model_ld(input logic [15:0] a, input logic [7:0] d);
      if (a >= 16'hFFFA) begin
         vec_m[a - 16'hFFFA] = d;
      end else if (a < 16'h1000) begin
         ram_m[a[5:0]] = d;
         wr_m[a[5:0]] = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk_ph1);
      #1;
   endtask

   // One edge carrying an optional CPU write and an optional backdoor write
   task automatic bus_cycle(input bit do_cpu, input logic [15:0] ca, input logic [7:0] cd,
                            input bit do_ld, input logic [15:0] la, input logic [7:0] lpd);
      bus.Addr_bus = ca;
      bus.Data_bus_out = cd;
      bus.R_nW = !do_cpu;
      ld_we = do_ld;
      ld_addr = la;
      ld_data = lpd;
      step();
      bus.R_nW = 1'b1;
      ld_we = 1'b0;
      if (do_cpu) model_cpu(ca, cd);
      if (do_ld) model_ld(la, lpd);
   endtask

   task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a);
      bus.Addr_bus = a;
      bus.R_nW = 1'b1;
      #1;
      check_val(tag, bus.Data_bus_in, exp_read(a));
   endtask

   function automatic logic [15:0] rand_cpu_addr();
      case ($urandom_range(0, 3))
         0: return 16'($urandom_range(0, 63));
         1: return 16'h6000;
         2: return 16'h0000 + 16'hFFFA + 16'($urandom_range(0, 5));
         default: return 16'($urandom_range(16'h1000, 16'hFFF9));
      endcase
   endfunction

   initial begin
      logic [15:0] ca, la, ra;
      int s1, l1, p1, s2, l2, p2;

      bus.Addr_bus = '0;
      bus.Data_bus_out = '0;
      bus.R_nW = 1'b1;
      for (int i = 0; i < 64; i++) begin
         ram_m[i] = 8'h00;
         wr_m[i] = 1'b0;
      end
      model_reset();

      // Reset held three cycles
      step();
      check_val("rst_irq", bus.irq, 1);
      check_val("rst_nmi", bus.nmi, 1);
      check_val("rst_done", done, 0);
      check_val("rst_code", done_code, 0);
      step();
      step();
      check_val("rst_cyc", cyc, 0);
      rst = 1'b1;
      check_val("cyc0", cyc, 0);
      step();
      check_val("cyc1", cyc, 1);
      step();
      check_val("cyc2", cyc, 2);
      rd_chk("vec_fffe", 16'hFFFE);
      check_val("vec_fffe_const", bus.Data_bus_in, 8'h00);
      rd_chk("vec_ffff", 16'hFFFF);
      check_val("vec_ffff_const", bus.Data_bus_in, 8'h20);
      rd_chk("vec_fffc", 16'hFFFC);
      rd_chk("vec_fffd", 16'hFFFD);

      // Directed RAM, mailbox and unmapped reads
      bus_cycle(0, 16'h0000, 8'h00, 1, 16'h0000, 8'hA9);
      check_val("ld_a9_same_cycle", bus.Data_bus_in, 8'hA9);
      bus_cycle(0, 16'h0000, 8'h00, 1, 16'h0001, 8'hAA);
      rd_chk("ld_0001", 16'h0001);
      bus_cycle(1, 16'h0010, 8'h55, 0, 16'h0000, 8'h00);
      rd_chk("cpu_0010", 16'h0010);
      check_val("cpu_0010_const", bus.Data_bus_in, 8'h55);
      check_val("done_before_mbox", done, 0);
      bus_cycle(1, 16'h6000, 8'h3C, 0, 16'h0000, 8'h00);
      check_val("mbox_done", done, 1);
      check_val("mbox_code", done_code, 8'h3C);
      rd_chk("unmapped_8000", 16'h8000);
      bus_cycle(1, 16'hFFFE, 8'h77, 0, 16'h0000, 8'h00);
      rd_chk("vec_cpu_write_ignored", 16'hFFFE);

      // Randomized bus traffic
      for (int i = 0; i < 150; i++) begin
         ca = rand_cpu_addr();
         la = ($urandom_range(0, 3) == 0) ? 16'hFFFA + 16'($urandom_range(0, 5))
                                          : 16'($urandom_range(0, 63));
         if ($urandom_range(0, 4) == 0) la = ca;
         bus_cycle($urandom_range(0, 1) == 1, ca, 8'($urandom), $urandom_range(0, 1) == 1,
                   la, 8'($urandom));
         ra = rand_cpu_addr();
         if (ra < 16'h1000 && !wr_m[ra[5:0]]) ra = 16'hFFFA + 16'($urandom_range(0, 5));
         rd_chk("rand_read", ra);
         if (i % 10 == 0) begin
            check_val("rand_done", done, done_m);
            check_val("rand_code", done_code, code_m);
         end
      end
      check_val("rand_done_end", done, done_m);
      check_val("rand_code_end", done_code, code_m);

      // IRQ one-shot
      cfg_wr(3'd0, 16'd5);
      cfg_wr(3'd1, 16'd15);
      cfg_wr(3'd2, 16'd0);
      cfg_wr(3'd3, 16'd1);
      check_val("irq_k0", bus.irq, 1);
      for (int k = 1; k <= 30; k++) begin
         step();
         check_val($sformatf("irq_oneshot_k%0d", k), bus.irq, chan_model(k, 5, 15, 0));
         check_val("nmi_idle", bus.nmi, 1);
      end
      cfg_wr(3'd3, 16'd0);

      // NMI periodic, then disabled mid-pulse
      cfg_wr(3'd4, 16'd0);
      cfg_wr(3'd5, 16'd2);
      cfg_wr(3'd6, 16'd10);
      cfg_wr(3'd7, 16'd1);
      for (int k = 1; k <= 31; k++) begin
         step();
         check_val($sformatf("nmi_per_k%0d", k), bus.nmi, chan_model(k, 0, 2, 10));
      end
      check_val("nmi_low_before_dis", bus.nmi, 0);
      cfg_wr(3'd7, 16'd0);
      check_val("nmi_dis_next", bus.nmi, 1);
      for (int k = 0; k < 12; k++) begin
         step();
         check_val("nmi_dis_stays", bus.nmi, 1);
      end

      // Randomized concurrent channel configurations
      for (int r = 0; r < 6; r++) begin
         s1 = $urandom_range(0, 6); l1 = $urandom_range(0, 5);
         p1 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 12);
         s2 = $urandom_range(0, 6); l2 = $urandom_range(0, 5);
         p2 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 12);
         cfg_wr(3'd3, 16'd0);
         cfg_wr(3'd7, 16'd0);
         cfg_wr(3'd0, 16'(s1)); cfg_wr(3'd1, 16'(l1)); cfg_wr(3'd2, 16'(p1));
         cfg_wr(3'd4, 16'(s2)); cfg_wr(3'd5, 16'(l2)); cfg_wr(3'd6, 16'(p2));
         cfg_wr(3'd3, 16'd1);
         cfg_wr(3'd7, 16'd1);
         check_val("rc_irq_k1", bus.irq, chan_model(1, s1, l1, p1));
         check_val("rc_nmi_k0", bus.nmi, 1);
         for (int k = 1; k <= 40; k++) begin
            step();
            check_val($sformatf("rc%0d_irq", r), bus.irq, chan_model(k + 1, s1, l1, p1));
            check_val($sformatf("rc%0d_nmi", r), bus.nmi, chan_model(k, s2, l2, p2));
         end
      end
      cfg_wr(3'd3, 16'd0);
      cfg_wr(3'd7, 16'd0);

      // Same-byte collision: backdoor wins
      bus_cycle(1, 16'h0020, 8'h11, 1, 16'h0020, 8'h22);
      rd_chk("collision_0020", 16'h0020);
      check_val("collision_const", bus.Data_bus_in, 8'h22);

      // Reset during ACT keeps RAM, restores outputs and vectors
      cfg_wr(3'd0, 16'd1);
      cfg_wr(3'd1, 16'd20);
      cfg_wr(3'd2, 16'd0);
      cfg_wr(3'd3, 16'd1);
      step();
      step();
      step();
      check_val("irq_act_before_rst", bus.irq, chan_model(3, 1, 20, 0));
      rst = 1'b0;
      step();
      model_reset();
      check_val("rst2_irq", bus.irq, 1);
      check_val("rst2_nmi", bus.nmi, 1);
      check_val("rst2_cyc", cyc, 0);
      check_val("rst2_done", done, 0);
      check_val("rst2_code", done_code, 0);
      rd_chk("rst2_ram_0020", 16'h0020);
      rd_chk("rst2_vec_ffff", 16'hFFFF);
      rst = 1'b1;
      step();
      step();
      check_val("rst2_irq_stays_idle", bus.irq, 1);
      check_val("rst2_cyc_runs", cyc, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
